// File: rtl/bcd_to_binary.sv
// Serial BCD digit link receiver: rebuilds hundreds/tens/ones digits into an 8-bit binary value.
// Latency: a place change registered at edge k is acted on at edge k+1 (outputs visible after k+1).
// Backpressure: none, the link has no flow control; malformed or stalled frames are dropped with an error pulse.
//
// Ports:
//   clock         in   1  single clock, posedge
//   reset         in   1  asynchronous, active-high
//   digit         in   4  BCD digit for the current place
//   digit_place   in   2  2=hundreds, 1=tens, 0=ones (3 never sent)
//   binary        out  8  last good value, held between frames
//   binary_valid  out  1  one-cycle pulse when binary updates
//   error_strobe  out  1  one-cycle pulse when a frame is aborted
//   error_code    out  2  0=sequence 1=bad digit 2=overflow 3=timeout, held between strobes
module bcd_to_binary #(
   parameter int TIMEOUT_POW2 = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] digit,
   input  logic [1:0] digit_place,
   output logic [7:0] binary,
   output logic       binary_valid,
   output logic       error_strobe,
   output logic [1:0] error_code
);

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      GOT_H = 2'd1,
      GOT_T = 2'd2
   } state_t;

   localparam logic [1:0] ERR_SEQ     = 2'd0;
   localparam logic [1:0] ERR_DIGIT   = 2'd1;
   localparam logic [1:0] ERR_OVF     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   state_t                  state_q, state_d;
   logic [3:0]              digit_q, digit_d;
   logic [1:0]              place_q, place_d;
   logic [1:0]              place_prev_q, place_prev_d;
   logic [9:0]              acc_q, acc_d;
   logic [TIMEOUT_POW2-1:0] timer_q, timer_d;
   logic [7:0]              binary_q, binary_d;
   logic                    binary_valid_q, binary_valid_d;
   logic                    error_strobe_q, error_strobe_d;
   logic [1:0]              error_code_q, error_code_d;

   logic       accept;
   logic       bad_digit;
   logic       timeout;
   logic [9:0] acc_next;

   // Each place is held for several cycles, so only the change of place marks a new digit.
   assign accept    = (place_q != place_prev_q);
   assign bad_digit = (digit_q > 4'd9);
   assign timeout   = &timer_q;
   // acc never exceeds 99 before scaling, so acc*10+digit fits in 10 bits.
   assign acc_next  = (acc_q << 3) + (acc_q << 1) + {6'd0, digit_q};

   always_comb begin
      state_d        = state_q;
      digit_d        = digit;
      place_d        = digit_place;
      place_prev_d   = place_q;
      acc_d          = acc_q;
      timer_d        = '0;
      binary_d       = binary_q;
      binary_valid_d = 1'b0;
      error_strobe_d = 1'b0;
      error_code_d   = error_code_q;

      if (accept) begin
         // timer_d stays 0: every accepted digit restarts the inter-digit timeout.
         if (state_q != HUNT && bad_digit) begin
            error_strobe_d = 1'b1;
            error_code_d   = ERR_DIGIT;
            state_d        = HUNT;
         end else begin
            case (state_q)
               HUNT: begin
                  // Resync: only a good hundreds digit opens a frame, anything else is dropped silently.
                  if (place_q == 2'd2 && !bad_digit) begin
                     acc_d   = {6'd0, digit_q};
                     state_d = GOT_H;
                  end
               end
               GOT_H: begin
                  case (place_q)
                     2'd1: begin
                        acc_d   = acc_next;
                        state_d = GOT_T;
                     end
                     2'd2: begin
                        error_strobe_d = 1'b1;
                        error_code_d   = ERR_SEQ;
                        acc_d          = {6'd0, digit_q};
                     end
                     default: begin
                        error_strobe_d = 1'b1;
                        error_code_d   = ERR_SEQ;
                        state_d        = HUNT;
                     end
                  endcase
               end
               GOT_T: begin
                  case (place_q)
                     2'd0: begin
                        if (acc_next <= 10'd255) begin
                           binary_d       = acc_next[7:0];
                           binary_valid_d = 1'b1;
                        end else begin
                           error_strobe_d = 1'b1;
                           error_code_d   = ERR_OVF;
                        end
                        state_d = HUNT;
                     end
                     2'd2: begin
                        // A new hundreds digit restarts the frame rather than just aborting it.
                        error_strobe_d = 1'b1;
                        error_code_d   = ERR_SEQ;
                        acc_d          = {6'd0, digit_q};
                        state_d        = GOT_H;
                     end
                     default: begin
                        error_strobe_d = 1'b1;
                        error_code_d   = ERR_SEQ;
                        state_d        = HUNT;
                     end
                  endcase
               end
               default: state_d = HUNT;
            endcase
         end
      end else if (state_q != HUNT) begin
         if (timeout) begin
            error_strobe_d = 1'b1;
            error_code_d   = ERR_TIMEOUT;
            state_d        = HUNT;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= HUNT;
         digit_q        <= 4'd0;
         // place_q also resets to the unused place 3, so the reset value itself never counts as a digit
         // while the first real sample after reset always differs from place_prev.
         place_q        <= 2'b11;
         place_prev_q   <= 2'b11;
         acc_q          <= 10'd0;
         timer_q        <= '0;
         binary_q       <= 8'd0;
         binary_valid_q <= 1'b0;
         error_strobe_q <= 1'b0;
         error_code_q   <= 2'd0;
      end else begin
         state_q        <= state_d;
         digit_q        <= digit_d;
         place_q        <= place_d;
         place_prev_q   <= place_prev_d;
         acc_q          <= acc_d;
         timer_q        <= timer_d;
         binary_q       <= binary_d;
         binary_valid_q <= binary_valid_d;
         error_strobe_q <= error_strobe_d;
         error_code_q   <= error_code_d;
      end
   end

   assign binary       = binary_q;
   assign binary_valid = binary_valid_q;
   assign error_strobe = error_strobe_q;
   assign error_code   = error_code_q;

endmodule
